wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: the pipeline has priority, and long-latency results wait in a 4-entry FIFO.
// Define WB_SCOREBOARD_EN to build the q_busy scoreboard; without it q_busy is tied to 0.
module wb_arbiter (
  input  logic        clk,
  input  logic        clrn,
  input  logic        p_we,
  input  logic [4:0]  p_wn,
  input  logic [31:0] p_d,
  input  logic        l_valid,
  input  logic [4:0]  l_wn,
  input  logic [31:0] l_d,
  output logic        l_ready,
  input  logic [4:0]  q_rn,
  output logic        q_busy,
  output logic        stall_req,
  output logic        we,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic [2:0]  count
);

  logic [4:0]  wn_mem_r [4];
  logic [31:0] d_mem_r  [4];
  logic [3:0]  valid_r;
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  count_r;
  logic [2:0]  starve_r;
  logic        we_r;
  logic [4:0]  wn_r;
  logic [31:0] d_r;

  logic        p_win_s;
  logic        pop_s;
  logic        push_s;
  logic        ready_s;

  // The FIFO only drains on cycles the pipeline leaves free. The pop decision reads count_r, so a result pushed this cycle cannot also be popped this cycle.
  assign p_win_s = p_we && (p_wn != 5'd0);
  assign pop_s   = !p_win_s && (count_r != 3'd0);
  assign ready_s = (count_r < 3'd4);
  assign push_s  = l_valid && ready_s && (l_wn != 5'd0);

  assign l_ready   = ready_s;
  assign stall_req = (starve_r >= 3'd3) || (count_r == 3'd4);
  assign we        = we_r;
  assign wn        = wn_r;
  assign d         = d_r;
  assign count     = count_r;

  // Write-port arbitration, FIFO storage, occupancy and starvation tracking
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we_r     <= 1'b0;
      wn_r     <= 5'd0;
      d_r      <= 32'd0;
      valid_r  <= 4'd0;
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      starve_r <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        wn_mem_r[i] <= 5'd0;
        d_mem_r[i]  <= 32'd0;
      end
    end else begin
      if (p_win_s) begin
        we_r <= 1'b1;
        wn_r <= p_wn;
        d_r  <= p_d;
      end else if (pop_s) begin
        we_r <= 1'b1;
        wn_r <= wn_mem_r[rd_ptr_r];
        d_r  <= d_mem_r[rd_ptr_r];
      end else begin
        we_r <= 1'b0;
      end

      if (push_s) begin
        wn_mem_r[wr_ptr_r] <= l_wn;
        d_mem_r[wr_ptr_r]  <= l_d;
        valid_r[wr_ptr_r]  <= 1'b1;
        wr_ptr_r           <= wr_ptr_r + 2'd1;
      end

      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + 2'd1;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase

      // The starvation counter saturates so that stall_req cannot drop out during a long run of pipeline writes.
      if (pop_s || (count_r == 3'd0)) begin
        starve_r <= 3'd0;
      end else if (p_win_s && (starve_r != 3'd7)) begin
        starve_r <= starve_r + 3'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [3:0] hit_s;

  // Match q_rn against every FIFO entry that still holds a pending write
  always_comb begin
    hit_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      hit_s[i] = valid_r[i] && (wn_mem_r[i] == q_rn);
    end
  end

  assign q_busy = (q_rn != 5'd0) &&
                  ((|hit_s) || (l_valid && ready_s && (l_wn == q_rn)));
`else
  logic unused_q_rn_s;
  assign unused_q_rn_s = &{1'b0, q_rn, valid_r};
  assign q_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: outputs are compared against a queue-based model every cycle, plus directed literal checks.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        p_we;
  logic [4:0]  p_wn;
  logic [31:0] p_d;
  logic        l_valid;
  logic [4:0]  l_wn;
  logic [31:0] l_d;
  logic        l_ready;
  logic [4:0]  q_rn;
  logic        q_busy;
  logic        stall_req;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [2:0]  count;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_arbiter u_dut (
    .clk(clk), .clrn(clrn),
    .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
    .l_valid(l_valid), .l_wn(l_wn), .l_d(l_d), .l_ready(l_ready),
    .q_rn(q_rn), .q_busy(q_busy), .stall_req(stall_req),
    .we(we), .wn(wn), .d(d), .count(count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: pending results kept in a queue, oldest first
  logic [4:0]  mq_wn[$];
  logic [31:0] mq_d[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wn;
  logic [31:0] m_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq_wn.delete();
    mq_d.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_wn = 5'd0;
    m_d  = 32'd0;
  endtask

  task automatic compare_all();
    int sz;
    logic busy;
    sz = mq_wn.size();
    busy = 1'b0;
    if (SB && q_rn != 5'd0) begin
      foreach (mq_wn[i]) if (mq_wn[i] == q_rn) busy = 1'b1;
      if (l_valid && sz < 4 && l_wn == q_rn) busy = 1'b1;
    end
    check("we", we, m_we);
    check("wn", wn, m_wn);
    check("d", d, m_d);
    check("count", count, sz);
    check("l_ready", l_ready, sz < 4);
    check("stall_req", stall_req, (m_starve >= 3) || (sz == 4));
    check("q_busy", q_busy, busy);
  endtask

  task automatic model_step();
    int sz0;
    bit pwin;
    sz0  = mq_wn.size();
    pwin = p_we && (p_wn != 5'd0);
    if (pwin) begin
      m_we = 1'b1; m_wn = p_wn; m_d = p_d;
    end else if (sz0 > 0) begin
      m_we = 1'b1; m_wn = mq_wn.pop_front(); m_d = mq_d.pop_front();
    end else begin
      m_we = 1'b0;
    end
    if (l_valid && sz0 < 4 && l_wn != 5'd0) begin
      mq_wn.push_back(l_wn);
      mq_d.push_back(l_d);
    end
    if (sz0 == 0 || !pwin) m_starve = 0;
    else if (m_starve < 7) m_starve = m_starve + 1;
  endtask

  // One cycle: compare the DUT against the model, advance the model, then wait for the next falling edge
  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic pwe, input logic [4:0] pwn, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lwn, input logic [31:0] ld);
    p_we = pwe; p_wn = pwn; p_d = pd; l_valid = lv; l_wn = lwn; l_d = ld;
  endtask

  // Assert clrn partway through the low clock phase and hold it across one rising edge
  task automatic mid_reset();
    #2 clrn = 1'b0;
    model_reset();
    #1;
    check("rst_we", we, 1'b0);
    check("rst_count", count, 3'd0);
    compare_all();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0;
    q_rn = 5'd0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_we", we, 1'b0);
    check("reset_count", count, 3'd0);
    check("reset_l_ready", l_ready, 1'b1);
    check("reset_stall", stall_req, 1'b0);
    check("reset_q_busy", q_busy, 1'b0);
    compare_all();
    clrn = 1'b1;
    @(negedge clk);

    // Single long-latency result: one cycle to enqueue, one cycle to write back
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 check("lat_count1", count, 3'd1);
    tick();
    #1;
    check("lat_we", we, 1'b1);
    check("lat_wn", wn, 5'd5);
    check("lat_d", d, 32'h11);
    check("lat_count0", count, 3'd0);

    // Fill the FIFO while the pipeline holds the port, then drain it in order
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    set_in(1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
    #1;
    check("full_count", count, 3'd4);
    check("full_l_ready", l_ready, 1'b0);
    check("full_stall", stall_req, 1'b1);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_we", we, 1'b1);
      check("drain_wn", wn, 5'(i));
      tick();
    end

    // Starvation: one queued entry while the pipeline wins three cycles in a row
    mid_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h77);
    tick();
    set_in(1'b1, 5'd7, 32'h5, 1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    #1 check("starve_stall", stall_req, 1'b1);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    #1;
    check("starve_pop_wn", wn, 5'd10);
    check("starve_release", stall_req, 1'b0);
    check("starve_count", count, 3'd0);

    // Register 0 from either source is not a write
    set_in(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    repeat (4) begin
      tick();
      #1;
      check("r0_count", count, 3'd0);
      check("r0_we", we, 1'b0);
    end

    // Scoreboard query
    set_in(1'b1, 5'd9, 32'h1, 1'b1, 5'd6, 32'h66);
    tick();
    set_in(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0);
    q_rn = 5'd6;
    #1 check("busy_r6", q_busy, SB);
    q_rn = 5'd0;
    #1 check("busy_r0", q_busy, 1'b0);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Reset with three writes pending: none of them may reach the write port
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 5'd9, 32'h2, 1'b1, 5'(20 + i), 32'(i));
      tick();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 check("pre_rst_count", count, 3'd3);
    mid_reset();
    repeat (4) begin
      tick();
      #1 check("post_rst_we", we, 1'b0);
    end

    // Randomized traffic with alternating light and heavy pipeline phases
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pct;
      pct = ((cyc / 150) % 2 == 1) ? 85 : 25;
      set_in($urandom_range(0, 99) < pct, 5'($urandom_range(0, 15)), $urandom(),
             $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom());
      q_rn = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) mid_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
